// File: rtl/data_cache_if.sv
// data_cache_if: LSU-side and backing-memory-side signals of the L1 data cache.
//   LSU side : data_req, data_we, data_addr, wdata, byte_enable -> cache
//              data_valid, rdata                               <- cache
//   Bus side : bus_req, bus_we, bus_addr, bus_wdata, bus_be     <- cache
//              bus_ack, bus_rdata                               -> cache
// Modports: slave  = the cache itself
//           master = the environment (LSU + backing memory)
interface data_cache_if #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned BYTE_DATA_WIDTH = 4
);
  logic                       data_req;
  logic                       data_we;
  logic [DATA_WIDTH-1:0]      data_addr;
  logic [DATA_WIDTH-1:0]      wdata;
  logic [BYTE_DATA_WIDTH-1:0] byte_enable;
  logic                       data_valid;
  logic [DATA_WIDTH-1:0]      rdata;

  logic                       bus_req;
  logic                       bus_we;
  logic [DATA_WIDTH-1:0]      bus_addr;
  logic [DATA_WIDTH-1:0]      bus_wdata;
  logic [BYTE_DATA_WIDTH-1:0] bus_be;
  logic                       bus_ack;
  logic [DATA_WIDTH-1:0]      bus_rdata;

  modport slave (
    input  data_req, data_we, data_addr, wdata, byte_enable,
    output data_valid, rdata,
    output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    input  bus_ack, bus_rdata
  );

  modport master (
    output data_req, data_we, data_addr, wdata, byte_enable,
    input  data_valid, rdata,
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-through, no-write-allocate L1 data cache.
// One data word per line, 2**INDEX_BITS lines. Misses and all stores with a
// non-zero byte enable go to a single-outstanding backing-memory bus.
// Ports:
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset
//   cache_if : data_cache_if.slave (LSU request/response + backing bus)
//   hit_count_o / miss_count_o : present only when DATA_CACHE_STATS_EN is
//              defined; count load/store (be != 0) hits and misses, wrap at 2^32.
// All outputs are registered. Request-to-data_valid latency on a hit is 2 cycles.
module data_cache #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned BYTE_DATA_WIDTH = 4,
  parameter int unsigned INDEX_BITS      = 6
) (
  input  logic         clk,
  input  logic         rst,
`ifdef DATA_CACHE_STATS_EN
  output logic [31:0]  hit_count_o,
  output logic [31:0]  miss_count_o,
`endif
  data_cache_if.slave  cache_if
);

  localparam int unsigned LINES = 1 << INDEX_BITS;
  localparam int unsigned TAG_W = DATA_WIDTH - INDEX_BITS - 2;
  localparam logic [DATA_WIDTH-1:0] ADDR_LSB_MASK = DATA_WIDTH'(3);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_REFILL,
    S_WRITE,
    S_RESP
  } state_e;

  state_e                     state_q;
  logic [DATA_WIDTH-1:0]      addr_q;
  logic                       we_q;
  logic [DATA_WIDTH-1:0]      wdata_q;
  logic [BYTE_DATA_WIDTH-1:0] be_q;

  logic [LINES-1:0]           valid_q;
  logic [TAG_W-1:0]           tag_mem  [LINES];
  logic [DATA_WIDTH-1:0]      data_mem [LINES];

  logic                       data_valid_q;
  logic [DATA_WIDTH-1:0]      rdata_q;
  logic                       bus_req_q;
  logic                       bus_we_q;
  logic [DATA_WIDTH-1:0]      bus_addr_q;
  logic [DATA_WIDTH-1:0]      bus_wdata_q;
  logic [BYTE_DATA_WIDTH-1:0] bus_be_q;

  logic [INDEX_BITS-1:0]      idx;
  logic [TAG_W-1:0]           tag;
  logic                       hit;
  logic [DATA_WIDTH-1:0]      line_data;
  logic [DATA_WIDTH-1:0]      merged;
  logic                       arr_we;
  logic [DATA_WIDTH-1:0]      arr_wdata;

  // Lookup and array write port. Both store-hit merges and refills land on
  // the line selected by the latched address, so a single write port suffices.
  always_comb begin
    idx       = addr_q[INDEX_BITS+1:2];
    tag       = addr_q[DATA_WIDTH-1:INDEX_BITS+2];
    line_data = data_mem[idx];
    hit       = valid_q[idx] && (tag_mem[idx] == tag);
    merged    = line_data;
    for (int unsigned b = 0; b < BYTE_DATA_WIDTH; b++) begin
      if (be_q[b]) begin
        merged[8*b +: 8] = wdata_q[8*b +: 8];
      end
    end
    arr_we    = 1'b0;
    arr_wdata = merged;
    if (state_q == S_LOOKUP && we_q && be_q != '0 && hit) begin
      arr_we = 1'b1;
    end else if (state_q == S_REFILL && cache_if.bus_ack) begin
      arr_we    = 1'b1;
      arr_wdata = cache_if.bus_rdata;
    end
    if (rst) begin
      arr_we = 1'b0;
    end
  end

  // Tag/data storage carries no reset; validity is tracked by valid_q alone.
  always_ff @(posedge clk) begin
    if (arr_we) begin
      data_mem[idx] <= arr_wdata;
      tag_mem[idx]  <= tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      valid_q      <= '0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      be_q         <= '0;
      data_valid_q <= 1'b0;
      rdata_q      <= '0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      bus_be_q     <= '0;
    end else begin
      data_valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (cache_if.data_req) begin
            addr_q  <= cache_if.data_addr & ~ADDR_LSB_MASK;
            we_q    <= cache_if.data_we;
            wdata_q <= cache_if.wdata;
            be_q    <= cache_if.byte_enable;
            state_q <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (we_q && be_q == '0) begin
            rdata_q      <= '0;
            data_valid_q <= 1'b1;
            state_q      <= S_RESP;
          end else if (!we_q && hit) begin
            rdata_q      <= line_data;
            data_valid_q <= 1'b1;
            state_q      <= S_RESP;
          end else begin
            // Load miss or any enabled store: start the bus transaction.
            bus_req_q   <= 1'b1;
            bus_we_q    <= we_q;
            bus_addr_q  <= addr_q;
            bus_wdata_q <= we_q ? wdata_q : '0;
            bus_be_q    <= we_q ? be_q : '1;
            state_q     <= we_q ? S_WRITE : S_REFILL;
          end
        end
        S_REFILL: begin
          if (cache_if.bus_ack) begin
            valid_q[idx] <= 1'b1;
            rdata_q      <= cache_if.bus_rdata;
            bus_req_q    <= 1'b0;
            data_valid_q <= 1'b1;
            state_q      <= S_RESP;
          end
        end
        S_WRITE: begin
          if (cache_if.bus_ack) begin
            rdata_q      <= '0;
            bus_req_q    <= 1'b0;
            data_valid_q <= 1'b1;
            state_q      <= S_RESP;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cache_if.data_valid = data_valid_q;
  assign cache_if.rdata      = rdata_q;
  assign cache_if.bus_req    = bus_req_q;
  assign cache_if.bus_we     = bus_we_q;
  assign cache_if.bus_addr   = bus_addr_q;
  assign cache_if.bus_wdata  = bus_wdata_q;
  assign cache_if.bus_be     = bus_be_q;

`ifdef DATA_CACHE_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == S_LOOKUP && (!we_q || be_q != '0)) begin
      if (hit) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end else begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_count_o  = hit_cnt_q;
  assign miss_count_o = miss_cnt_q;
`endif

endmodule
